// File: rtl/sdram_req_arbiter_if.sv
// Request/response/controller bus bundle for sdram_req_arbiter.
// slave = arbiter side, master = traffic sources + controller side.
interface sdram_req_arbiter_if #(
  parameter int ADDR_WIDTH = 24,
  parameter int DATA_WIDTH = 16
);
  logic                  reader_valid_i;
  logic                  reader_ready_o;
  logic [ADDR_WIDTH-1:0] reader_addr_i;
  logic                  writer_valid_i;
  logic                  writer_ready_o;
  logic [ADDR_WIDTH-1:0] writer_addr_i;
  logic [DATA_WIDTH-1:0] writer_data_i;
  logic                  resp_valid_o;
  logic                  resp_ready_i;
  logic [DATA_WIDTH-1:0] resp_data_o;
  logic                  resp_last_o;
  logic                  ctrl_cmd_valid_o;
  logic                  ctrl_cmd_ready_i;
  logic                  ctrl_cmd_we_o;
  logic [ADDR_WIDTH-1:0] ctrl_cmd_addr_o;
  logic                  ctrl_wdata_valid_o;
  logic                  ctrl_wdata_ready_i;
  logic [DATA_WIDTH-1:0] ctrl_wdata_o;
  logic                  ctrl_rdata_valid_i;
  logic [DATA_WIDTH-1:0] ctrl_rdata_i;

  modport slave (
    input  reader_valid_i, reader_addr_i,
    output reader_ready_o,
    input  writer_valid_i, writer_addr_i, writer_data_i,
    output writer_ready_o,
    output resp_valid_o, resp_data_o, resp_last_o,
    input  resp_ready_i,
    output ctrl_cmd_valid_o, ctrl_cmd_we_o, ctrl_cmd_addr_o,
    input  ctrl_cmd_ready_i,
    output ctrl_wdata_valid_o, ctrl_wdata_o,
    input  ctrl_wdata_ready_i,
    input  ctrl_rdata_valid_i, ctrl_rdata_i
  );

  modport master (
    output reader_valid_i, reader_addr_i,
    input  reader_ready_o,
    output writer_valid_i, writer_addr_i, writer_data_i,
    input  writer_ready_o,
    input  resp_valid_o, resp_data_o, resp_last_o,
    output resp_ready_i,
    input  ctrl_cmd_valid_o, ctrl_cmd_we_o, ctrl_cmd_addr_o,
    output ctrl_cmd_ready_i,
    input  ctrl_wdata_valid_o, ctrl_wdata_o,
    output ctrl_wdata_ready_i,
    output ctrl_rdata_valid_i, ctrl_rdata_i
  );
endinterface

// File: rtl/sdram_req_arbiter.sv
// Round-robin front-end for SDRAM burst reads/writes: one controller command
// per burst, write data passed through, read data returned via an FWFT FIFO.
module sdram_req_arbiter #(
  parameter int ADDR_WIDTH   = 24,
  parameter int DATA_WIDTH   = 16,
  parameter int BURST_LENGTH = 8,
  parameter int RFIFO_DEPTH  = 16
) (
  input  logic                clk_axi,
  input  logic                rstn_axi,
  sdram_req_arbiter_if.slave  bus,
  output logic                busy_o,
  output logic                err_o
);

  localparam int BEAT_W = $clog2(BURST_LENGTH);
  localparam int PTR_W  = $clog2(RFIFO_DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LENGTH - 1);
  localparam logic [PTR_W:0]    RD_OCC_MAX = (PTR_W + 1)'(RFIFO_DEPTH - BURST_LENGTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_CMD,
    S_WR_DATA,
    S_RD_CMD,
    S_RD_WAIT
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_w_q;  // 0 = reader served last
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BEAT_W-1:0]     beat_q;
  logic [PTR_W:0]        wr_ptr_q, rd_ptr_q, occupancy;
  logic [DATA_WIDTH:0]   mem [RFIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic                  fifo_empty, push, pop;
  logic                  wr_elig, rd_elig, grant_w, grant_r;
  logic                  wr_beat, last_beat;

  assign occupancy  = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (occupancy == '0);
  assign last_beat  = (beat_q == LAST_BEAT);

  // Reads need a whole burst of FIFO space reserved up front, since the
  // controller's read strobe cannot be stalled; same-cycle pops are not credited.
  assign wr_elig = bus.writer_valid_i;
  assign rd_elig = bus.reader_valid_i && (occupancy <= RD_OCC_MAX);
  assign grant_w = (state_q == S_IDLE) && wr_elig && (!rd_elig || !last_grant_w_q);
  assign grant_r = (state_q == S_IDLE) && rd_elig && !grant_w;

  assign wr_beat = (state_q == S_WR_DATA) && bus.writer_valid_i && bus.ctrl_wdata_ready_i;
  assign push    = (state_q == S_RD_WAIT) && bus.ctrl_rdata_valid_i;
  assign pop     = !fifo_empty && bus.resp_ready_i;

  always_comb begin
    state_d                = state_q;
    bus.reader_ready_o     = 1'b0;
    bus.writer_ready_o     = 1'b0;
    bus.ctrl_cmd_valid_o   = 1'b0;
    bus.ctrl_cmd_we_o      = 1'b0;
    bus.ctrl_wdata_valid_o = 1'b0;
    bus.ctrl_wdata_o       = '0;
    case (state_q)
      S_IDLE: begin
        bus.writer_ready_o = grant_w;
        bus.reader_ready_o = grant_r;
        if (grant_w)      state_d = S_WR_CMD;
        else if (grant_r) state_d = S_RD_CMD;
      end
      S_WR_CMD: begin
        bus.ctrl_cmd_valid_o = 1'b1;
        bus.ctrl_cmd_we_o    = 1'b1;
        if (bus.ctrl_cmd_ready_i) state_d = S_WR_DATA;
      end
      S_WR_DATA: begin
        bus.ctrl_wdata_valid_o = bus.writer_valid_i;
        bus.writer_ready_o     = bus.ctrl_wdata_ready_i;
        bus.ctrl_wdata_o       = bus.writer_data_i;
        if (wr_beat && last_beat) state_d = S_IDLE;
      end
      S_RD_CMD: begin
        bus.ctrl_cmd_valid_o = 1'b1;
        if (bus.ctrl_cmd_ready_i) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (push && last_beat) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_axi or negedge rstn_axi) begin
    if (!rstn_axi) begin
      state_q        <= S_IDLE;
      last_grant_w_q <= 1'b0;
      addr_q         <= '0;
      beat_q         <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      err_o          <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_w) begin
        addr_q         <= bus.writer_addr_i;
        beat_q         <= '0;
        last_grant_w_q <= 1'b1;
      end else if (grant_r) begin
        addr_q         <= bus.reader_addr_i;
        beat_q         <= '0;
        last_grant_w_q <= 1'b0;
      end else if (wr_beat || push) begin
        beat_q <= beat_q + 1'b1;
      end
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (bus.ctrl_rdata_valid_i && (state_q != S_RD_WAIT)) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_axi) begin
    if (push) mem[wr_ptr_q[PTR_W-1:0]] <= {last_beat, bus.ctrl_rdata_i};
  end

  // Storage is not reset, so the head is masked to keep outputs at zero when empty.
  assign head             = mem[rd_ptr_q[PTR_W-1:0]];
  assign bus.resp_valid_o = !fifo_empty;
  assign bus.resp_data_o  = fifo_empty ? '0 : head[DATA_WIDTH-1:0];
  assign bus.resp_last_o  = !fifo_empty && head[DATA_WIDTH];
  assign bus.ctrl_cmd_addr_o = addr_q;
  assign busy_o           = (state_q != S_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Directed + randomized bench for sdram_req_arbiter: the bench plays the SDRAM
// controller (word store), and predicts grants and the read-response stream.
module tb_sdram_req_arbiter;
  localparam int AW    = 24;
  localparam int DW    = 16;
  localparam int BL    = 8;
  localparam int DEPTH = 16;

  logic clk_axi  = 1'b0;
  logic rstn_axi = 1'b0;
  logic busy_o, err_o;

  always #5 clk_axi = ~clk_axi;

  sdram_req_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sdram_req_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .BURST_LENGTH(BL),
    .RFIFO_DEPTH (DEPTH)
  ) dut (
    .clk_axi (clk_axi),
    .rstn_axi(rstn_axi),
    .bus     (bus),
    .busy_o  (busy_o),
    .err_o   (err_o)
  );

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } resp_t;

  int          checks   = 0;
  int          failures = 0;
  logic [DW-1:0] sdram [int unsigned];
  resp_t       exp_q [$];
  bit          last_w;      // grant history: 1 = writer served last
  int          rr_mode;     // resp_ready policy: 0 hold, 1 always, 2 random
  bit          gw;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Called at negedge+1 with inputs settled; checks the response stream,
  // advances one clock and returns at the following negedge.
  task automatic tick();
    bit p;
    check("resp_valid", bus.resp_valid_o, exp_q.size() != 0);
    if (exp_q.size() != 0) begin
      check("resp_data", bus.resp_data_o, exp_q[0].data);
      check("resp_last", bus.resp_last_o, exp_q[0].last);
    end
    p = (exp_q.size() != 0) && bus.resp_ready_i && rstn_axi;
    @(posedge clk_axi);
    if (p) void'(exp_q.pop_front());
    @(negedge clk_axi);
    case (rr_mode)
      0:       bus.resp_ready_i = 1'b0;
      1:       bus.resp_ready_i = 1'b1;
      default: bus.resp_ready_i = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic do_reset();
    rstn_axi = 1'b0;
    bus.reader_valid_i = 0; bus.reader_addr_i = '0;
    bus.writer_valid_i = 0; bus.writer_addr_i = '0; bus.writer_data_i = '0;
    bus.resp_ready_i = 0; bus.ctrl_cmd_ready_i = 0; bus.ctrl_wdata_ready_i = 0;
    bus.ctrl_rdata_valid_i = 0; bus.ctrl_rdata_i = '0;
    rr_mode = 0;
    exp_q.delete();
    last_w = 1'b0;
    #1;
    check("rst_reader_ready", bus.reader_ready_o, 0);
    check("rst_writer_ready", bus.writer_ready_o, 0);
    check("rst_resp_valid", bus.resp_valid_o, 0);
    check("rst_resp_data", bus.resp_data_o, 0);
    check("rst_resp_last", bus.resp_last_o, 0);
    check("rst_cmd_valid", bus.ctrl_cmd_valid_o, 0);
    check("rst_cmd_we", bus.ctrl_cmd_we_o, 0);
    check("rst_cmd_addr", bus.ctrl_cmd_addr_o, 0);
    check("rst_wdata_valid", bus.ctrl_wdata_valid_o, 0);
    check("rst_wdata", bus.ctrl_wdata_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_err", err_o, 0);
    repeat (2) @(negedge clk_axi);
    rstn_axi = 1'b1;
  endtask

  // Waits in IDLE for a grant, checking both readies against the arbitration rule.
  task automatic accept(output bit granted_w);
    bit ew, er, wel, rel, done;
    done = 0;
    granted_w = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      #1;
      wel = bus.writer_valid_i;
      rel = bus.reader_valid_i && (exp_q.size() <= DEPTH - BL);
      ew  = wel && (!rel || !last_w);
      er  = rel && !ew;
      check("grant_writer_ready", bus.writer_ready_o, ew);
      check("grant_reader_ready", bus.reader_ready_o, er);
      tick();
      if (ew || er) begin
        last_w    = ew;
        granted_w = ew;
        done      = 1;
      end
    end
    check("grant_timeout", done, 1);
  endtask

  task automatic cmd_phase(input int unsigned addr, input bit we, input bit directed);
    bit rdy, done;
    done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      rdy = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.ctrl_cmd_ready_i = rdy;
      #1;
      check("cmd_valid", bus.ctrl_cmd_valid_o, 1);
      check("cmd_we", bus.ctrl_cmd_we_o, we);
      check("cmd_addr", bus.ctrl_cmd_addr_o, addr);
      check("ready_in_cmd", {bus.writer_ready_o, bus.reader_ready_o}, 0);
      tick();
      done = rdy;
    end
    check("cmd_timeout", done, 1);
    bus.ctrl_cmd_ready_i = 0;
  endtask

  task automatic wr_tail(input int unsigned addr, input int unsigned nbeats,
                         input bit directed, input bit keep_valid);
    int unsigned beat;
    bit v, r;
    logic [DW-1:0] d;
    cmd_phase(addr, 1'b1, directed);
    beat = 0;
    for (int c = 0; c < 400 && beat < nbeats; c++) begin
      v = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      r = directed ? 1'b1 : ($urandom_range(0, 3) != 0);
      d = directed ? DW'(16'hA500 + beat) : DW'($urandom);
      bus.writer_valid_i = v; bus.writer_data_i = d; bus.ctrl_wdata_ready_i = r;
      #1;
      check("wr_cmd_once", bus.ctrl_cmd_valid_o, 0);
      check("wdata_valid", bus.ctrl_wdata_valid_o, v);
      check("wdata", bus.ctrl_wdata_o, d);
      check("wr_ready_pass", bus.writer_ready_o, r);
      tick();
      if (v && r) begin
        sdram[addr + beat] = d;
        beat++;
      end
    end
    check("wr_beats", beat, nbeats);
    bus.writer_valid_i = keep_valid;
    bus.ctrl_wdata_ready_i = 0;
  endtask

  task automatic rd_tail(input int unsigned addr, input bit directed);
    int unsigned beat;
    bit s;
    resp_t e;
    cmd_phase(addr, 1'b0, directed);
    beat = 0;
    for (int c = 0; c < 400 && beat < BL; c++) begin
      s = directed ? 1'b1 : ($urandom_range(0, 2) != 0);
      bus.ctrl_rdata_valid_i = s;
      bus.ctrl_rdata_i = s ? sdram[addr + beat] : DW'($urandom);
      #1;
      check("rd_cmd_once", bus.ctrl_cmd_valid_o, 0);
      tick();
      if (s) begin
        e.last = (beat == BL - 1);
        e.data = sdram[addr + beat];
        exp_q.push_back(e);
        beat++;
      end
    end
    check("rd_beats", beat, BL);
    bus.ctrl_rdata_valid_i = 0;
  endtask

  task automatic drain();
    rr_mode = 1;
    bus.resp_ready_i = 1;
    for (int c = 0; c < 200 && exp_q.size() != 0; c++) begin
      #1;
      tick();
    end
    check("drain_empty", exp_q.size(), 0);
    #1;
    check("busy_after_drain", busy_o, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    @(negedge clk_axi);
    do_reset();

    // Directed write burst, controller always ready
    bus.writer_valid_i = 1; bus.writer_addr_i = 24'h001000;
    accept(gw);
    check("t1_grant_is_write", gw, 1);
    wr_tail(32'h001000, BL, 1'b1, 1'b0);
    #1;
    check("t1_busy_idle", busy_o, 0);
    @(negedge clk_axi);

    // Directed read burst, response one cycle behind each strobe
    rr_mode = 1; bus.resp_ready_i = 1;
    bus.reader_valid_i = 1; bus.reader_addr_i = 24'h001000;
    accept(gw);
    check("t2_grant_is_read", gw, 0);
    bus.reader_valid_i = 0;
    rd_tail(32'h001000, 1'b1);
    drain();
    @(negedge clk_axi);

    // Fill FIFO under back-pressure; third read refused until occupancy <= 8
    bus.writer_valid_i = 1; bus.writer_addr_i = 24'h002000;
    accept(gw);
    wr_tail(32'h002000, BL, 1'b0, 1'b0);
    rr_mode = 0; bus.resp_ready_i = 0;
    bus.reader_valid_i = 1; bus.reader_addr_i = 24'h001000;
    accept(gw);
    bus.reader_valid_i = 0;
    rd_tail(32'h001000, 1'b0);
    bus.reader_valid_i = 1; bus.reader_addr_i = 24'h002000;
    accept(gw);
    bus.reader_valid_i = 0;
    rd_tail(32'h002000, 1'b0);
    bus.reader_valid_i = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      check("t3_busy_hold", busy_o, 1);
      tick();
    end
    check("t3_fifo_full", exp_q.size(), DEPTH);
    rr_mode = 2;
    bus.reader_valid_i = 1; bus.reader_addr_i = 24'h002000;
    accept(gw);
    bus.reader_valid_i = 0;
    rd_tail(32'h002000, 1'b0);
    drain();
    @(negedge clk_axi);

    // Alternating grants with both channels continuously requesting
    do_reset();
    rr_mode = 1; bus.resp_ready_i = 1;
    bus.writer_valid_i = 1; bus.writer_addr_i = 24'h003000;
    bus.reader_valid_i = 1; bus.reader_addr_i = 24'h003000;
    for (int k = 0; k < 4; k++) begin
      accept(gw);
      check("t4_alternate", gw, (k % 2) == 0);
      if (gw) wr_tail(32'h003000, BL, 1'b0, 1'b1);
      else    rd_tail(32'h003000, 1'b0);
    end
    bus.writer_valid_i = 0; bus.reader_valid_i = 0;
    drain();
    @(negedge clk_axi);

    // Stray read strobe in IDLE: no push, sticky error
    bus.ctrl_rdata_valid_i = 1; bus.ctrl_rdata_i = DW'($urandom);
    #1;
    check("t5_err_before", err_o, 0);
    tick();
    bus.ctrl_rdata_valid_i = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t5_err_sticky", err_o, 1);
      tick();
    end
    do_reset();

    // Reset in the middle of a write burst, then a clean write/read
    bus.writer_valid_i = 1; bus.writer_addr_i = 24'h004000;
    accept(gw);
    wr_tail(32'h004000, 4, 1'b1, 1'b1);
    bus.writer_data_i = 16'h5A5A;
    do_reset();
    bus.writer_valid_i = 1; bus.writer_addr_i = 24'h005000;
    accept(gw);
    check("t6_grant_is_write", gw, 1);
    wr_tail(32'h005000, BL, 1'b0, 1'b0);
    rr_mode = 2;
    bus.reader_valid_i = 1; bus.reader_addr_i = 24'h005000;
    accept(gw);
    check("t6_grant_is_read", gw, 0);
    bus.reader_valid_i = 0;
    rd_tail(32'h005000, 1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
